// File: rtl/dm_resp_pkg.sv
// Shared MMIO map, finish magic, status layout and address-region decode for dm_responder.
package dm_resp_pkg;

   localparam logic [15:0] ADDR_FINISH = 16'hFFFF;
   localparam logic [15:0] ADDR_CONTX  = 16'hFFFE;
   localparam logic [15:0] ADDR_STATUS = 16'hFFFD;
   localparam logic [15:0] ADDR_CYCLES = 16'hFFFC;

   localparam logic [31:0] FINISH_MAGIC = 32'hFFFF_F000;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [2:0] {
      REG_MEM,
      REG_FIN,
      REG_CON,
      REG_STAT,
      REG_CYC
   } region_e;

   function automatic region_e decode_region(input logic [15:0] addr);
      region_e r;
      case (addr)
         ADDR_FINISH: r = REG_FIN;
         ADDR_CONTX:  r = REG_CON;
         ADDR_STATUS: r = REG_STAT;
         ADDR_CYCLES: r = REG_CYC;
         default:     r = REG_MEM;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dm_con_fifo.sv
// Synchronous console FIFO: wrap-bit pointers, head data exposed combinationally.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module dm_con_fifo
   import dm_resp_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic [W-1:0]              push_data_i,
   input  logic                      pop_i,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic [W-1:0]              head_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  wr_q, wr_d;
   logic [PW:0]  rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         push_ok_s;
   logic         pop_ok_s;

   assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign empty_o   = (wr_q == rd_q);
   assign count_o   = wr_q - rd_q;
   assign pop_ok_s  = pop_i && !empty_o;
   assign push_ok_s = push_i && (!full_o || pop_ok_s);

   // Pointer next-state and head data
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok_s) begin
         wr_d = wr_q + {{PW{1'b0}}, 1'b1};
      end else begin
         wr_d = wr_q;
      end
      if (pop_ok_s) begin
         rd_d = rd_q + {{PW{1'b0}}, 1'b1};
      end else begin
         rd_d = rd_q;
      end
      if (empty_o) begin
         head_o = {W{1'b0}};
      end else begin
         head_o = mem_q[rd_q[PW-1:0]];
      end
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= {(PW+1){1'b0}};
         rd_q <= {(PW+1){1'b0}};
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage; when full, the slot written is the one being popped this edge
   always_ff @(posedge clk) begin
      if (rst && push_ok_s) begin
         mem_q[wr_q[PW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/dm_responder.sv
// CPU data-memory responder: word SRAM plus finish/console/status/cycle MMIO.
// Optional cycle counter enabled by defining DM_CYCLE_CNT_EN.
module dm_responder
   import dm_resp_pkg::*;
#(
   parameter int MEM_AW     = 14,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DM_enable,
   input  logic        DM_write,
   input  logic [15:0] DM_address,
   input  logic [31:0] DM_in,
   output logic [31:0] DM_out,
   output logic        con_valid,
   output logic [7:0]  con_data,
   input  logic        con_ready,
   output logic        done,
   output logic        overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   region_e            region_s;
   logic               rd_s;
   logic               wr_s;
   logic               con_push_s;
   logic               con_pop_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [CW-1:0]      fifo_count_s;
   logic [7:0]         fifo_head_s;
   logic [31:0]        status_s;
   logic [31:0]        cyc_val_s;
   logic [31:0]        rdata_s;
   logic [MEM_AW-1:0]  mem_idx_s;

   logic [31:0]        dm_out_q, dm_out_d;
   logic               done_q, done_d;
   logic               overflow_q, overflow_d;
   logic [31:0]        mem_q [2**MEM_AW];

   assign region_s   = decode_region(DM_address);
   assign rd_s       = DM_enable && !DM_write;
   assign wr_s       = DM_enable && DM_write;
   assign mem_idx_s  = DM_address[MEM_AW-1:0];
   assign con_push_s = wr_s && (region_s == REG_CON);
   assign con_pop_s  = con_valid && con_ready;

   dm_con_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_con_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (con_push_s),
      .push_data_i (DM_in[7:0]),
      .pop_i       (con_pop_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .count_o     (fifo_count_s),
      .head_o      (fifo_head_s)
   );

   assign con_valid = !fifo_empty_s;
   assign con_data  = fifo_head_s;

   always_comb begin
      status_s = 32'h0;
      status_s[STAT_COUNT_LSB +: 8] = 8'(fifo_count_s);
      status_s[STAT_EMPTY_BIT]      = fifo_empty_s;
      status_s[STAT_FULL_BIT]       = fifo_full_s;
   end

`ifdef DM_CYCLE_CNT_EN
   logic [31:0] cyc_q, cyc_d;

   // Counter stops once done is already set, and saturates at all-ones
   always_comb begin
      if (!done_q && (cyc_q != 32'hFFFF_FFFF)) begin
         cyc_d = cyc_q + 32'd1;
      end else begin
         cyc_d = cyc_q;
      end
   end

   // Cycle counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_q <= 32'h0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign cyc_val_s = cyc_q;
`else
   assign cyc_val_s = 32'h0;
`endif

   // Read mux and flag next-state; MMIO reads see pre-edge state
   always_comb begin
      rdata_s    = 32'h0;
      dm_out_d   = dm_out_q;
      done_d     = done_q;
      overflow_d = overflow_q;
      case (region_s)
         REG_MEM:  rdata_s = mem_q[mem_idx_s];
         REG_FIN:  rdata_s = {31'b0, done_q};
         REG_CON:  rdata_s = 32'h0;
         REG_STAT: rdata_s = status_s;
         REG_CYC:  rdata_s = cyc_val_s;
         default:  rdata_s = 32'h0;
      endcase
      if (rd_s) begin
         dm_out_d = rdata_s;
      end else begin
         dm_out_d = dm_out_q;
      end
      if (wr_s && (region_s == REG_FIN) && (DM_in == FINISH_MAGIC)) begin
         done_d = 1'b1;
      end else begin
         done_d = done_q;
      end
      if (con_push_s && fifo_full_s && !con_pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Read data and sticky flag registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         dm_out_q   <= 32'h0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         dm_out_q   <= dm_out_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

   // Backing store is never cleared by reset
   always_ff @(posedge clk) begin
      if (rst && wr_s && (region_s == REG_MEM)) begin
         mem_q[mem_idx_s] <= DM_in;
      end
   end

   assign DM_out   = dm_out_q;
   assign done     = done_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: read and console expectations are queued by the
// stimulus and consumed by a monitor on the falling edge.
module tb_dm_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        DM_enable = 1'b0;
   logic        DM_write = 1'b0;
   logic [15:0] DM_address = 16'h0;
   logic [31:0] DM_in = 32'h0;
   logic [31:0] DM_out;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready = 1'b0;
   logic        done;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_exp [$];
   string       rd_name [$];
   logic [7:0]  con_exp [$];

   logic        rd_pend = 1'b0;
   logic [31:0] cyc_m = 32'h0;
   logic        done_m = 1'b0;

   dm_responder dut (
      .clk        (clk),
      .rst        (rst),
      .DM_enable  (DM_enable),
      .DM_write   (DM_write),
      .DM_address (DM_address),
      .DM_in      (DM_in),
      .DM_out     (DM_out),
      .con_valid  (con_valid),
      .con_data   (con_data),
      .con_ready  (con_ready),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A read strobe sampled at an edge produces DM_out after that edge
   always @(posedge clk) rd_pend <= rst && DM_enable && !DM_write;

   // Cycle counter model: counts edges after reset release, freezes once done is set
   always @(posedge clk) begin
      if (!rst) begin
         cyc_m  = 32'h0;
         done_m = 1'b0;
      end else begin
         if (!done_m && cyc_m != 32'hFFFF_FFFF) cyc_m = cyc_m + 32'd1;
         if (DM_enable && DM_write && DM_address == 16'hFFFF && DM_in == 32'hFFFF_F000)
            done_m = 1'b1;
      end
   end

   function automatic logic [31:0] cyc_exp();
`ifdef DM_CYCLE_CNT_EN
      return cyc_m;
`else
      return 32'h0;
`endif
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (rd_pend) begin
         if (rd_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: DM_out %h with no expectation", DM_out);
         end else begin
            check(rd_name.pop_front(), DM_out, rd_exp.pop_front());
         end
      end
      if (con_valid && con_ready) begin
         if (con_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_con: con_data %h with no expectation", con_data);
         end else begin
            check("con_data", {24'h0, con_data}, {24'h0, con_exp.pop_front()});
         end
      end
   end

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      DM_enable = 1'b1; DM_write = 1'b1; DM_address = a; DM_in = d;
      @(posedge clk); #1;
      DM_enable = 1'b0; DM_write = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [31:0] e, input string n);
      DM_enable = 1'b1; DM_write = 1'b0; DM_address = a;
      rd_exp.push_back(e);
      rd_name.push_back(n);
      @(posedge clk); #1;
      DM_enable = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string n, input int budget);
      int k = 0;
      while ((con_valid || con_exp.size() != 0) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(n, {31'b0, (k < budget)}, 32'h1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_dm_out", DM_out, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_overflow", {31'b0, overflow}, 32'h0);
      check("rst_con_valid", {31'b0, con_valid}, 32'h0);
      check("rst_con_data", {24'h0, con_data}, 32'h0);
      rst = 1'b1;

      // Counter 100 edges after release
      idle(100);
`ifdef DM_CYCLE_CNT_EN
      rd(16'hFFFC, 32'd100, "cycles_100");
`else
      rd(16'hFFFC, 32'd0, "cycles_off");
`endif

      // SRAM and aliasing
      wr(16'h0010, 32'hDEAD_BEEF);
      rd(16'h0010, 32'hDEAD_BEEF, "sram_rd");
      rd(16'h4010, 32'hDEAD_BEEF, "sram_alias");
      wr(16'h3FFF, 32'h0123_4567);
      rd(16'hBFFF, 32'h0123_4567, "sram_alias_top");
      rd(16'hFFFF, 32'h0, "fin_rd_idle");
      rd(16'hFFFE, 32'h0, "contx_rd");

      // Console basic
      wr(16'hFFFE, 32'h0000_0048); con_exp.push_back(8'h48);
      wr(16'hFFFE, 32'h0000_0069); con_exp.push_back(8'h69);
      rd(16'hFFFD, 32'h0000_0200, "status_two");
      con_ready = 1'b1;
      drain("drain_hi", 20);
      check("con_valid_after_hi", {31'b0, con_valid}, 32'h0);
      con_ready = 1'b0;
      rd(16'hFFFD, 32'h0000_0002, "status_empty");

      // Fill, overflow, full+push+pop
      for (int i = 0; i < 16; i++) begin
         wr(16'hFFFE, 32'h10 + 32'(i));
         con_exp.push_back(8'h10 + 8'(i));
      end
      check("ovf_before", {31'b0, overflow}, 32'h0);
      rd(16'hFFFD, 32'h0000_1001, "status_full");
      wr(16'hFFFE, 32'h0000_00EE);
      check("ovf_after_drop", {31'b0, overflow}, 32'h1);
      con_ready = 1'b1;
      con_exp.push_back(8'hA5);
      wr(16'hFFFE, 32'h0000_00A5);
      con_ready = 1'b0;
      rd(16'hFFFD, 32'h0000_1001, "status_full_pushpop");
      check("ovf_pushpop", {31'b0, overflow}, 32'h1);
      con_ready = 1'b1;
      drain("drain_full", 40);
      con_ready = 1'b0;
      check("con_valid_after_full", {31'b0, con_valid}, 32'h0);

      // Finish flag
      wr(16'hFFFF, 32'h0000_1234);
      check("done_bad_magic", {31'b0, done}, 32'h0);
      rd(16'hFFFF, 32'h0, "fin_rd0");
      wr(16'hFFFF, 32'hFFFF_F000);
      check("done_set", {31'b0, done}, 32'h1);
      rd(16'hFFFF, 32'h1, "fin_rd1");

      // Counter frozen after done; SRAM still live
      rd(16'hFFFC, cyc_exp(), "cyc_frozen_a");
      idle(10);
      rd(16'hFFFC, cyc_exp(), "cyc_frozen_b");
      wr(16'h0020, 32'hCAFE_F00D);
      rd(16'h0020, 32'hCAFE_F00D, "sram_after_done");

      // Reset mid-run
      for (int i = 0; i < 5; i++) begin
         wr(16'hFFFE, 32'h30 + 32'(i));
      end
      rd(16'hFFFD, 32'h0000_0500, "status_five");
      rd(16'h0010, 32'hDEAD_BEEF, "sram_pre_rst");
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_done", {31'b0, done}, 32'h0);
      check("mid_rst_con_valid", {31'b0, con_valid}, 32'h0);
      check("mid_rst_dm_out", DM_out, 32'h0);
      check("mid_rst_overflow", {31'b0, overflow}, 32'h0);
      rst = 1'b1;
      rd(16'h0010, 32'hDEAD_BEEF, "sram_kept");
      rd(16'hFFFD, 32'h0000_0002, "status_after_rst");
      rd(16'hFFFF, 32'h0, "fin_after_rst");

      idle(3);
      check("rd_queue_empty", 32'(rd_exp.size()), 32'h0);
      check("con_queue_empty", 32'(con_exp.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
